// File: rtl/d_latch.sv
// Gate-controlled data capture register with change tracking (q loads d while g is high, holds otherwise).
// Latency: d/g to q is 1 cycle; 3 cycles when D_LATCH_SYNC_EN adds 2-flop input synchronizers.
// Backpressure: none; inputs are sampled every cycle and outputs are always valid to consume.
module d_latch #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             g,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             upd,
    output logic [CNT_W-1:0] chg_cnt
);

    // Effective gate and data after optional synchronization
    logic             g_e;
    logic [WIDTH-1:0] d_e;

`ifdef D_LATCH_SYNC_EN
    logic             g_s1;
    logic             g_s2;
    logic [WIDTH-1:0] d_s1;
    logic [WIDTH-1:0] d_s2;

    // Two-flop synchronizers on gate and data; cleared by reset so stale
    // pre-reset inputs never reach q afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_s1 <= 1'b0;
            g_s2 <= 1'b0;
            d_s1 <= '0;
            d_s2 <= '0;
        end else begin
            g_s1 <= g;
            g_s2 <= g_s1;
            d_s1 <= d;
            d_s2 <= d_s1;
        end
    end

    assign g_e = g_s2;
    assign d_e = d_s2;
`else
    assign g_e = g;
    assign d_e = d;
`endif

    logic [WIDTH-1:0] q_nxt;
    logic             changed;
    logic             cnt_sat;

    // Next q value and whether this edge actually changes it
    always_comb begin
        q_nxt   = q;
        changed = 1'b0;
        cnt_sat = &chg_cnt;
        if (g_e) begin
            q_nxt = d_e;
        end
        changed = (q_nxt != q);
    end

    // State register: reset wins over the gate; upd/chg_cnt only react to real value changes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
            upd     <= 1'b0;
            chg_cnt <= '0;
        end else begin
            q   <= q_nxt;
            upd <= changed;
            if (g_e) begin
                q_valid <= 1'b1;
            end
            if (changed && !cnt_sat) begin
                chg_cnt <= chg_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_d_latch.sv
module tb_d_latch;

`ifdef D_LATCH_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    localparam int        RW     = 4;
    localparam int        RCW    = 5;
    localparam logic [3:0] R_RST = 4'hA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Directed instance: WIDTH=1, RESET_VAL=0, CNT_W=2 (saturation visible quickly)
    logic       a_rst_n = 1'b0;
    logic       a_g     = 1'b0;
    logic [0:0] a_d     = 1'b0;
    logic [0:0] a_q;
    logic       a_v;
    logic       a_u;
    logic [1:0] a_c;

    // Random instance: WIDTH=4, RESET_VAL=A, CNT_W=5
    logic          b_rst_n = 1'b0;
    logic          b_g     = 1'b0;
    logic [RW-1:0] b_d     = '0;
    logic [RW-1:0] b_q;
    logic          b_v;
    logic          b_u;
    logic [RCW-1:0] b_c;

    d_latch #(.WIDTH(1), .RESET_VAL(1'b0), .CNT_W(2)) u_a (
        .clk(clk), .rst_n(a_rst_n), .g(a_g), .d(a_d),
        .q(a_q), .q_valid(a_v), .upd(a_u), .chg_cnt(a_c)
    );

    d_latch #(.WIDTH(RW), .RESET_VAL(R_RST), .CNT_W(RCW)) u_b (
        .clk(clk), .rst_n(b_rst_n), .g(b_g), .d(b_d),
        .q(b_q), .q_valid(b_v), .upd(b_u), .chg_cnt(b_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference for the random instance: inputs reach the capture
    // logic LAT-1 edges late, and reset forgets everything still in flight.
    typedef struct packed {
        logic          g;
        logic [RW-1:0] d;
    } eff_t;

    eff_t           hist[$];
    logic [RW-1:0]  m_q;
    logic           m_v;
    logic           m_u;
    int             m_c;
    bit             model_on = 1'b0;

    task automatic model_edge(input logic r, input logic gg, input logic [RW-1:0] dd);
        eff_t e;
        if (!r) begin
            m_q = R_RST;
            m_v = 1'b0;
            m_u = 1'b0;
            m_c = 0;
            hist.delete();
            for (int k = 0; k < LAT - 1; k++) hist.push_back('0);
        end else begin
            hist.push_back({gg, dd});
            e   = hist.pop_front();
            m_u = 1'b0;
            if (e.g) begin
                m_v = 1'b1;
                if (e.d != m_q) begin
                    m_q = e.d;
                    m_u = 1'b1;
                    if (m_c < (1 << RCW) - 1) m_c = m_c + 1;
                end
            end
        end
    endtask

    // One clock edge; inputs are stable across it and outputs are read 1 time unit later
    task automatic tick();
        logic          r;
        logic          gg;
        logic [RW-1:0] dd;
        r  = b_rst_n;
        gg = b_g;
        dd = b_d;
        @(posedge clk);
        if (model_on) model_edge(r, gg, dd);
        #1;
    endtask

    typedef struct {
        logic       rst_n;
        logic       g;
        logic       d;
        logic       q;
        logic       v;
        logic       u;
        logic [1:0] c;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // rst_n, g, d  ->  q, q_valid, upd, chg_cnt (observed after the vector took effect)
        tbl[0]  = '{1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b1, 2'd1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 2'd2};
        tbl[4]  = '{1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b1, 2'd3};
        tbl[5]  = '{1'b1, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 2'd3};
        tbl[6]  = '{1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 2'd3};
        tbl[7]  = '{1'b1, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 2'd3};
        tbl[8]  = '{1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 2'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 2'd3};
        tbl[10] = '{1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b1, 2'd3};
        tbl[11] = '{1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b1, 2'd3};
        tbl[12] = '{1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 2'd3};
        tbl[13] = '{1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 2'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 2'd0};
        tbl[15] = '{1'b1, 1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 2'd0};
        tbl[16] = '{1'b1, 1'b1, 1'b1,  1'b1, 1'b1, 1'b1, 2'd1};

        // Each vector is held LAT edges so it fully propagates in either build
        for (int i = 0; i < 17; i++) begin
            a_rst_n = tbl[i].rst_n;
            a_g     = tbl[i].g;
            a_d     = tbl[i].d;
            for (int k = 0; k < LAT; k++) tick();
            chk($sformatf("row%0d q", i),       32'(a_q), 32'(tbl[i].q));
            chk($sformatf("row%0d q_valid", i), 32'(a_v), 32'(tbl[i].v));
            chk($sformatf("row%0d upd", i),     32'(a_u), 32'(tbl[i].u));
            chk($sformatf("row%0d chg_cnt", i), 32'(a_c), 32'(tbl[i].c));
        end

        // Latency: q=1 now; d falls with g high, q follows on exactly the LAT-th edge
        a_d = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk($sformatf("lat edge%0d q", k), 32'(a_q), (k == LAT) ? 32'd0 : 32'd1);
        end
        chk("lat chg_cnt", 32'(a_c), 32'd2);
        tick();
        chk("lat upd drop", 32'(a_u), 32'd0);

        // Reset in the middle of a transparent phase overrides the capture
        a_d = 1'b1;
        a_rst_n = 1'b0;
        tick();
        chk("midrst q", 32'(a_q), 32'd0);
        chk("midrst q_valid", 32'(a_v), 32'd0);
        chk("midrst chg_cnt", 32'(a_c), 32'd0);
        a_rst_n = 1'b1;
        for (int k = 0; k < LAT; k++) tick();
        chk("resume q", 32'(a_q), 32'd1);
        chk("resume chg_cnt", 32'(a_c), 32'd1);

        // Randomized run on the wide instance against the reference model
        model_on = 1'b1;
        b_rst_n = 1'b0;
        tick();
        tick();
        chk("rnd reset q", 32'(b_q), 32'(R_RST));
        chk("rnd reset cnt", 32'(b_c), 32'd0);
        for (int n = 0; n < 600; n++) begin
            b_rst_n = ($urandom_range(0, 59) != 0);
            b_g     = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) != 0) b_d = RW'($urandom_range(0, 15));
            tick();
            chk($sformatf("rnd%0d q", n),       32'(b_q), 32'(m_q));
            chk($sformatf("rnd%0d q_valid", n), 32'(b_v), 32'(m_v));
            chk($sformatf("rnd%0d upd", n),     32'(b_u), 32'(m_u));
            chk($sformatf("rnd%0d chg_cnt", n), 32'(b_c), 32'(m_c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
